// File: rtl/dac_tx_pkg.sv
// Shared types and defaults for the DAC serial transmitter.
`timescale 1ns/1ps
package dac_tx_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DATA_W_DEF          = 8;
    localparam int CTRL_W_DEF          = 8;
    localparam int FRAME_W             = CTRL_W_DEF + DATA_W_DEF;
    localparam logic [7:0] CTRL_WORD_DEF = 8'h40;
endpackage

// File: rtl/dac_tx_fifo.sv
// Small synchronous FIFO with count-based full/empty and show-ahead read data.
`timescale 1ns/1ps
module dac_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // A push into a full FIFO is fine when the same cycle frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dac_serial_tx.sv
// Serialises {control, sample} frames to a 3-wire SPI-style DAC.
// Optional input FIFO enabled by defining DAC_TX_FIFO_EN.
`timescale 1ns/1ps
module dac_serial_tx
    import dac_tx_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                CTRL_W     = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_WORD  = CTRL_WORD_DEF,
    parameter int                CLK_DIV    = 4,
    parameter int                CS_GAP     = 2,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              dac_sclk,
    output logic              dac_cs_n,
    output logic              dac_din,
    output logic              busy,
    output logic              frame_done
);
    localparam int FW   = CTRL_W + DATA_W;
    localparam int BW   = $clog2(FW);
    localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [HC_W-1:0] HALF_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [GW-1:0]   GAP_LAST  = GW'(CS_GAP - 1);
    localparam logic [BW-1:0]   BIT_FIRST = BW'(FW - 1);

    if (CLK_DIV < 1 || CS_GAP < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_bad_param
        $error("dac_serial_tx: illegal CLK_DIV, CS_GAP or FIFO_DEPTH");
    end

    state_t            state;
    logic [FW-2:0]     shreg;
    logic [BW-1:0]     bit_cnt;
    logic [HC_W-1:0]   half_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              avail, start;
    logic              chain;
    logic [DATA_W-1:0] load_data;
    logic [FW-1:0]     frame;

`ifdef DAC_TX_FIFO_EN
    logic fifo_full, fifo_empty;

    dac_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_valid && !fifo_full),
        .pop   (start),
        .wdata (sample_in),
        .rdata (load_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    assign sample_ready = !fifo_full;
    assign avail        = !fifo_empty;
    assign chain        = 1'b1;
`else
    assign sample_ready = (state == IDLE);
    assign avail        = sample_valid;
    assign load_data    = sample_in;
    assign chain        = 1'b0;
`endif

    // Only the FIFO build may run straight from the gap into the next frame.
    assign start = avail && ((state == IDLE) || (chain && state == GAP && gap_cnt == '0));
    assign frame = {CTRL_WORD, load_data};
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            half_cnt   <= '0;
            gap_cnt    <= '0;
            dac_sclk   <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_din    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start) begin
                state    <= SHIFT;
                shreg    <= frame[FW-2:0];
                dac_din  <= frame[FW-1];
                dac_cs_n <= 1'b0;
                dac_sclk <= 1'b0;
                bit_cnt  <= BIT_FIRST;
                half_cnt <= '0;
            end else begin
                case (state)
                    SHIFT: begin
                        if (half_cnt == HALF_LAST) begin
                            half_cnt <= '0;
                            if (!dac_sclk) begin
                                dac_sclk <= 1'b1;
                            end else if (bit_cnt == '0) begin
                                state      <= GAP;
                                dac_sclk   <= 1'b0;
                                dac_cs_n   <= 1'b1;
                                dac_din    <= 1'b0;
                                frame_done <= 1'b1;
                                gap_cnt    <= GAP_LAST;
                            end else begin
                                bit_cnt  <= bit_cnt - 1'b1;
                                dac_sclk <= 1'b0;
                                dac_din  <= shreg[FW-2];
                                shreg    <= shreg << 1;
                            end
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == '0) state <= IDLE;
                        else               gap_cnt <= gap_cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
